// File: rtl/pipe_pkg.sv
// Shared pipe definitions: opcodes, instruction field positions and the hazard-controller states.
package pipe_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_LD    = 6'b100000;
  localparam logic [5:0] OP_SD    = 6'b100001;
  localparam logic [5:0] OP_BEZ   = 6'b100010;
  localparam logic [5:0] OP_BNEZ  = 6'b100011;
  localparam logic [5:0] OP_NOP   = 6'b111100;

  // Field positions use the instruction's big-endian bit numbering (bit 0 = MSB).
  localparam int OPC_POS = 0;
  localparam int OPC_W   = 6;
  localparam int RD_POS  = 6;
  localparam int RA_POS  = 11;
  localparam int RB_POS  = 16;
  localparam int REG_W   = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  function automatic logic is_branch_op(input logic [5:0] opc);
    return (opc == OP_BEZ) || (opc == OP_BNEZ);
  endfunction
endpackage

// File: rtl/hazard_src_decode.sv
// Maps the ID instruction to its (up to two) source registers and a branch flag.
// Purely combinational, zero latency, no flow control.
module hazard_src_decode
  import pipe_pkg::*;
(
  input  logic [0:31] i_instr,
  output logic        o_s0_vld,
  output logic [4:0]  o_s0,
  output logic        o_s1_vld,
  output logic [4:0]  o_s1,
  output logic        o_is_branch
);
  logic [5:0] w_opc;
  logic [4:0] w_rd;
  logic [4:0] w_ra;
  logic [4:0] w_rb;
  logic       w_unused;

  assign w_opc       = i_instr[OPC_POS +: OPC_W];
  assign w_rd        = i_instr[RD_POS +: REG_W];
  assign w_ra        = i_instr[RA_POS +: REG_W];
  assign w_rb        = i_instr[RB_POS +: REG_W];
  assign w_unused    = ^i_instr[21:31];
  assign o_is_branch = is_branch_op(w_opc);

  always_comb begin
    o_s0_vld = 1'b0;
    o_s0     = '0;
    o_s1_vld = 1'b0;
    o_s1     = '0;
    case (w_opc)
      OP_RTYPE: begin
        o_s0_vld = 1'b1; o_s0 = w_ra;
        o_s1_vld = 1'b1; o_s1 = w_rb;
      end
      OP_LD: begin
        o_s0_vld = 1'b1; o_s0 = w_ra;
      end
      OP_SD: begin
        o_s0_vld = 1'b1; o_s0 = w_ra;
        o_s1_vld = 1'b1; o_s1 = w_rd;
      end
      OP_BEZ, OP_BNEZ: begin
        o_s0_vld = 1'b1; o_s0 = w_rd;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipe sequencer: load-use/branch-operand stalls, data-memory freeze, registered IF/ID flush.
// Stall/freeze outputs are same-cycle (Mealy); flush is one cycle late and is held while the pipe is frozen.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [0:31]      i_id_instr,
  input  logic             i_id_br_taken,
  input  logic             i_idex_regwrite,
  input  logic             i_idex_memread,
  input  logic [0:4]       i_idex_rd,
  input  logic             i_exmem_memreq,
  input  logic             i_dmem_ready,
  output logic             o_pc_stall,
  output logic             o_if2id_stall,
  output logic             o_if2id_flush,
  output logic             o_idex_bubble,
  output logic             o_pipe_freeze,
  output logic             o_mem_err,
  output logic [0:CNT_W-1] o_stall_cycles
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t             r_state;
  state_t             r_ret;
  logic [1:0]         r_stall_left;
  logic [WC_W-1:0]    r_wait_cnt;
  logic               r_flush;
  logic               r_mem_err;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_s0_vld, w_s1_vld, w_is_branch;
  logic [4:0]         w_s0, w_s1;
  logic               w_dep, w_mem_wait;
  logic [1:0]         w_n;
  logic               w_pc_stall, w_bubble, w_freeze;
  state_t             w_nxt_state, w_nxt_ret;
  logic [1:0]         w_nxt_left;

  hazard_src_decode u_src_decode (
    .i_instr     (i_id_instr),
    .o_s0_vld    (w_s0_vld),
    .o_s0        (w_s0),
    .o_s1_vld    (w_s1_vld),
    .o_s1        (w_s1),
    .o_is_branch (w_is_branch)
  );

  assign w_dep = i_idex_regwrite && (i_idex_rd != 5'd0) &&
                 ((w_s0_vld && (w_s0 == i_idex_rd)) || (w_s1_vld && (w_s1 == i_idex_rd)));
  // A load feeding a branch costs both the load delay and the early-resolve delay.
  assign w_n        = w_dep ? ({1'b0, i_idex_memread} + {1'b0, w_is_branch}) : 2'd0;
  assign w_mem_wait = i_exmem_memreq && !i_dmem_ready;

  always_comb begin
    w_pc_stall  = 1'b0;
    w_bubble    = 1'b0;
    w_freeze    = 1'b0;
    w_nxt_state = r_state;
    w_nxt_ret   = r_ret;
    w_nxt_left  = r_stall_left;
    case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          w_freeze = 1'b1; w_pc_stall = 1'b1;
          w_nxt_state = MEM_WAIT; w_nxt_ret = RUN;
        end else if (w_n != 2'd0) begin
          w_pc_stall = 1'b1; w_bubble = 1'b1;
          w_nxt_left  = w_n - 2'd1;
          w_nxt_state = (w_n == 2'd2) ? STALL : RUN;
        end
      end
      STALL: begin
        w_pc_stall = 1'b1;
        if (w_mem_wait) begin
          w_freeze = 1'b1;
          w_nxt_state = MEM_WAIT; w_nxt_ret = STALL;
        end else begin
          w_bubble   = 1'b1;
          w_nxt_left = r_stall_left - 2'd1;
          if (r_stall_left <= 2'd1) w_nxt_state = RUN;
        end
      end
      MEM_WAIT: begin
        if (!i_dmem_ready) begin
          w_freeze = 1'b1; w_pc_stall = 1'b1;
        end else begin
          w_nxt_state = r_ret;
        end
      end
      default: w_nxt_state = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= RUN;
      r_ret        <= RUN;
      r_stall_left <= 2'd0;
      r_wait_cnt   <= '0;
      r_flush      <= 1'b0;
      r_mem_err    <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_nxt_state;
      r_ret        <= w_nxt_ret;
      r_stall_left <= w_nxt_left;
      if (r_state == MEM_WAIT) begin
        if (i_dmem_ready) begin
          r_wait_cnt <= '0;
        end else if (r_wait_cnt != WC_W'(MEM_TIMEOUT)) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1)) r_mem_err <= 1'b1;
        end
      end
      // A pending flush must survive a freeze so the squash lands on the right instruction.
      if (!w_freeze) r_flush <= i_id_br_taken && !w_pc_stall;
      if (w_pc_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_pc_stall     = w_pc_stall && !i_reset;
  assign o_if2id_stall  = w_pc_stall && !i_reset;
  assign o_idex_bubble  = w_bubble && !i_reset;
  assign o_pipe_freeze  = w_freeze && !i_reset;
  assign o_if2id_flush  = r_flush && !i_reset;
  assign o_mem_err      = r_mem_err && !i_reset;
  assign o_stall_cycles = i_reset ? '0 : r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl with a queued scoreboard against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 5;
  localparam int TMO   = 64;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [0:31]      id_instr;
  logic             br, rw, mr, mreq, rdy;
  logic [0:4]       rd;
  logic             pc_stall, if_stall, flush, bubble, freeze, mem_err;
  logic [0:CNT_W-1] stall_cycles;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_id_instr      (id_instr),
    .i_id_br_taken   (br),
    .i_idex_regwrite (rw),
    .i_idex_memread  (mr),
    .i_idex_rd       (rd),
    .i_exmem_memreq  (mreq),
    .i_dmem_ready    (rdy),
    .o_pc_stall      (pc_stall),
    .o_if2id_stall   (if_stall),
    .o_if2id_flush   (flush),
    .o_idex_bubble   (bubble),
    .o_pipe_freeze   (freeze),
    .o_mem_err       (mem_err),
    .o_stall_cycles  (stall_cycles)
  );

  typedef struct {
    bit pc; bit ifs; bit fl; bit bub; bit frz; bit err; int cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model state: remaining extra stall cycles, whether memory is being waited on, and counters.
  int m_rem = 0, m_waited = 0, m_cnt = 0;
  bit m_in_wait = 0, m_err = 0, m_flush = 0;

  logic [5:0] ops [7] = '{OP_RTYPE, OP_LD, OP_SD, OP_BEZ, OP_BNEZ, OP_NOP, 6'b000111};

  function automatic logic [0:31] mk(input logic [5:0] o, input int d, input int a, input int b);
    logic [0:31] v;
    v = {o, 5'(d), 5'(a), 5'(b), 11'd0};
    return v;
  endfunction

  // Extra cycles needed: one for a load result, one more if a branch consumes it in ID.
  function automatic int hz_len(input logic [0:31] ins, input bit w, input bit m, input int d);
    logic [5:0] opc;
    int srcs[$];
    bit dep, is_br;
    opc = ins[0:5];
    if (opc == OP_RTYPE)                        srcs = '{int'(ins[11:15]), int'(ins[16:20])};
    else if (opc == OP_LD)                      srcs = '{int'(ins[11:15])};
    else if (opc == OP_SD)                      srcs = '{int'(ins[11:15]), int'(ins[6:10])};
    else if (opc == OP_BEZ || opc == OP_BNEZ)   srcs = '{int'(ins[6:10])};
    dep = 0;
    foreach (srcs[i]) if (w && d != 0 && srcs[i] == d) dep = 1;
    is_br = (opc == OP_BEZ || opc == OP_BNEZ);
    return dep ? (int'(m) + int'(is_br)) : 0;
  endfunction

  task automatic model_step(input bit r, input logic [0:31] ins, input bit b, input bit w,
                            input bit m, input int d, input bit mq, input bit ry);
    exp_t e;
    int   n;
    e = '{default: 0};
    if (r) begin
      m_rem = 0; m_waited = 0; m_cnt = 0; m_in_wait = 0; m_err = 0; m_flush = 0;
      q.push_back(e);
      return;
    end
    e.fl = m_flush; e.err = m_err; e.cnt = m_cnt;
    if (m_in_wait) begin
      if (ry) begin
        m_in_wait = 0; m_waited = 0;
      end else begin
        e.frz = 1; e.pc = 1; e.ifs = 1;
        m_waited++;
        if (m_waited >= TMO) m_err = 1;
      end
    end else if (m_rem > 0) begin
      e.pc = 1; e.ifs = 1;
      if (mq && !ry) begin
        e.frz = 1; m_in_wait = 1;
      end else begin
        e.bub = 1; m_rem--;
      end
    end else begin
      n = hz_len(ins, w, m, d);
      if (mq && !ry) begin
        e.frz = 1; e.pc = 1; e.ifs = 1; m_in_wait = 1;
      end else if (n > 0) begin
        e.pc = 1; e.ifs = 1; e.bub = 1; m_rem = n - 1;
      end
    end
    if (!e.frz) m_flush = b && !e.pc;
    if (e.pc && m_cnt < CMAX) m_cnt++;
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input logic [0:31] ins, input bit b, input bit w,
                       input bit m, input int d, input bit mq, input bit ry);
    reset = r; id_instr = ins; br = b; rw = w; mr = m; rd = 5'(d); mreq = mq; rdy = ry;
    model_step(r, ins, b, w, m, d, mq, ry);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 0, 1);
  endtask

  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_stall",     int'(pc_stall),     int'(e.pc));
        chk("if2id_stall",  int'(if_stall),     int'(e.ifs));
        chk("if2id_flush",  int'(flush),        int'(e.fl));
        chk("idex_bubble",  int'(bubble),       int'(e.bub));
        chk("pipe_freeze",  int'(freeze),       int'(e.frz));
        chk("mem_err",      int'(mem_err),      int'(e.err));
        chk("stall_cycles", int'(stall_cycles), e.cnt);
      end
    end
  end

  initial begin
    reset = 1; id_instr = mk(OP_NOP, 0, 0, 0); br = 0; rw = 0; mr = 0; rd = 0; mreq = 0; rdy = 1;
    @(posedge clk);
    #1;
    drive(1, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 0, 1);
    drive(1, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 0, 1);

    // Load-use: LD r3 in EX, RTYPE reading r3 in ID.
    drive(0, mk(OP_RTYPE, 1, 3, 4), 0, 1, 1, 3, 0, 1);
    drive(0, mk(OP_RTYPE, 1, 3, 4), 0, 0, 0, 0, 0, 1);
    idle(2);
    // Load feeding a branch: two stall cycles.
    drive(0, mk(OP_BEZ, 5, 0, 0), 0, 1, 1, 5, 0, 1);
    drive(0, mk(OP_BEZ, 5, 0, 0), 1, 0, 0, 0, 0, 1);
    drive(0, mk(OP_BEZ, 5, 0, 0), 1, 0, 0, 0, 0, 1);
    idle(2);
    // ALU result into a branch, SD reading rD, and r0 never hazards.
    drive(0, mk(OP_BNEZ, 7, 0, 0), 0, 1, 0, 7, 0, 1);
    drive(0, mk(OP_SD, 6, 2, 0), 0, 1, 1, 6, 0, 1);
    drive(0, mk(OP_RTYPE, 1, 0, 0), 0, 1, 1, 0, 0, 1);
    // Taken branch without hazard, then flush held across a freeze.
    drive(0, mk(OP_BNEZ, 2, 0, 0), 1, 0, 0, 0, 0, 1);
    idle(2);
    drive(0, mk(OP_BNEZ, 2, 0, 0), 1, 0, 0, 0, 0, 1);
    drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 0);
    drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 0);
    drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 1);
    idle(2);
    // Three-cycle memory wait.
    for (int i = 0; i < 3; i++) drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 0);
    drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 1);
    idle(2);
    // Timeout, then reset in the middle of the wait.
    for (int i = 0; i < 70; i++) drive(0, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 0);
    drive(1, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 1, 0);
    idle(3);
    // Memory wait landing in the STALL cycle of a load-branch stall.
    drive(1, mk(OP_NOP, 0, 0, 0), 0, 0, 0, 0, 0, 1);
    drive(0, mk(OP_BEZ, 5, 0, 0), 0, 1, 1, 5, 0, 1);
    drive(0, mk(OP_BEZ, 5, 0, 0), 0, 0, 0, 0, 1, 0);
    drive(0, mk(OP_BEZ, 5, 0, 0), 0, 0, 0, 0, 1, 0);
    drive(0, mk(OP_BEZ, 5, 0, 0), 0, 0, 0, 0, 1, 1);
    drive(0, mk(OP_BEZ, 5, 0, 0), 0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) == 0,
            mk(ops[$urandom_range(6)], $urandom_range(7), $urandom_range(7), $urandom_range(7)),
            $urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
            $urandom_range(7), $urandom_range(2) == 0, $urandom_range(3) != 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage pipe: IF, ID, EX, MEM, WB.
- Detects load-use and branch-operand hazards on the ID instruction, and freezes the pipe while data memory is not ready.
- Generates the registered IF/ID flush after a taken branch; this flush feeds the control unit's if2id_flush input.
- Sits beside the control unit and drives the stall/bubble enables of the PC and the stage registers.

Parameters:
- CNT_W, 16: width of the saturating stall-cycle performance counter.
- MEM_TIMEOUT, 64: consecutive MEM_WAIT cycles before mem_err is raised.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- id_instr  in  [0:31]  instruction in ID. opcode [0:5], rD [6:10], rA [11:15], rB [16:20].
- id_br_taken  in  1  branch resolved taken in ID this cycle.
- idex_regwrite  in  1  EX-stage instruction writes the register file.
- idex_memread  in  1  EX-stage instruction is a load.
- idex_rd  in  [0:4]  EX-stage destination register.
- exmem_memreq  in  1  MEM stage has a load or store this cycle.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- pc_stall  out  1  hold PC.
- if2id_stall  out  1  hold the IF/ID register.
- if2id_flush  out  1  squash the instruction now in ID.
- idex_bubble  out  1  load a NOP (all controls 0) into ID/EX.
- pipe_freeze  out  1  hold ID/EX and EX/MEM; bubble MEM/WB.
- mem_err  out  1  sticky memory timeout flag.
- stall_cycles  out  [0:CNT_W-1]  count of cycles with pc_stall=1, saturating.

Behaviour:
- Reset (synchronous):
  - state=RUN, stall_left=0, wait_cnt=0, if2id_flush=0, mem_err=0, stall_cycles=0.
  - While reset=1, all outputs are forced to 0.
- Source decode (opcodes in the shared package):
  - RTYPE: sources rA, rB.
  - LD: source rA.
  - SD: sources rA, rD.
  - BEZ/BNEZ: source rD.
  - NOP and unknown opcodes: no sources.
  - Register 0 never creates a hazard.
- dep = idex_regwrite & (idex_rd != 0) & (idex_rd matches any source of id_instr).
- Hazard length N, evaluated in RUN only:
  - N=2 if dep & idex_memread & the ID opcode is a branch.
  - N=1 if dep & idex_memread (non-branch).
  - N=1 if dep & the ID opcode is a branch (ALU result).
  - N=0 otherwise.
- Stall outputs are Mealy (same cycle as detection). if2id_flush is registered.
- RUN:
  - If exmem_memreq & !dmem_ready: pipe_freeze=pc_stall=if2id_stall=1, go to MEM_WAIT, ret=RUN.
  - Else if N>0: pc_stall=if2id_stall=idex_bubble=1, stall_left=N-1, go to STALL if N=2, else stay in RUN.
  - Else: no stall.
- STALL:
  - pc_stall=if2id_stall=idex_bubble=1.
  - If exmem_memreq & !dmem_ready: go to MEM_WAIT with ret=STALL; stall_left holds, idex_bubble=0.
  - Else: decrement stall_left; at 0, return to RUN next cycle.
- MEM_WAIT:
  - pipe_freeze=pc_stall=if2id_stall=1, idex_bubble=0.
  - wait_cnt increments each cycle; when it reaches MEM_TIMEOUT, mem_err<=1 (sticky until reset). Waiting continues regardless.
  - On dmem_ready=1: freeze deasserts in that cycle, wait_cnt<=0, next state=ret.
- Flush:
  - if2id_flush<=1 for exactly one cycle after a cycle with id_br_taken=1 & pc_stall=0.
  - id_br_taken during any stall is ignored; the branch re-resolves when the stall ends.
- Simultaneous events:
  - MEM wait beats hazard stall, which beats flush capture.
  - A flush already registered is still emitted in a cycle that enters MEM_WAIT. It stays high until the first non-frozen cycle, then clears.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at all-ones.
- Reset mid-STALL or mid-MEM_WAIT returns to RUN with no residual bubble or flush.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants: OP_RTYPE=6'b101010, OP_LD=6'b100000, OP_SD=6'b100001, OP_BEZ=6'b100010, OP_BNEZ=6'b100011, OP_NOP=6'b111100.
  - instruction field index constants.
  - state encoding: RUN, STALL, MEM_WAIT.
- Sub-module hazard_src_decode: combinational; maps id_instr to source-valid bits, source register numbers and an is_branch flag.

Test Plan:
- Load-use: EX = LD r3 (idex_memread=1, idex_rd=3), ID = RTYPE rA=3 -> one cycle of pc_stall=if2id_stall=idex_bubble=1, then 0. stall_cycles=1.
- Load-branch: EX = LD r5, ID = BEZ rD=5 -> stall for exactly 2 cycles, passing through the STALL state, then RUN.
- Taken branch: id_br_taken=1 with no hazard -> if2id_flush=1 in the next cycle only. With idex_rd=0 and a matching source field -> no stall.
- Memory wait: exmem_memreq=1, dmem_ready=0 for 3 cycles -> pipe_freeze=1 for those 3 cycles, 0 in the cycle dmem_ready=1. mem_err stays 0.
- Timeout plus reset: dmem_ready held 0 for 70 cycles -> mem_err=1 from cycle 64. Asserting reset for 1 cycle mid-wait -> all outputs 0, state RUN.
- Wait during stall: LD-branch stall, with MEM wait asserted in the first stall cycle for 2 cycles -> 1 stall cycle + 2 frozen cycles + the remaining 1 stall cycle. Total stall_cycles=4.
